kb_link_tx: RTL and testbench
=============================

// Module: kb_link_tx
// PURPOSE
//  Keypad-side transmitter for the alarm keyboard link (2-bit code + receive strobe) consumed by the main alarm controller.
//  Buffers key codes from the keypad scanner in a small FIFO.
//  Replays each code on KB_OUT with a timed setup/strobe/hold/gap frame on KB_SEND, so the controller samples it cleanly.
// PARAMETERS
//  DEPTH       4  FIFO entries; power of 2, >=2
//  SETUP_CYC   1  cycles KB_OUT is stable before KB_SEND rises; >=1
//  STROBE_CYC  2  cycles KB_SEND is held high; >=1
//  HOLD_CYC    1  cycles KB_OUT is held after KB_SEND falls; >=1
//  GAP_CYC     1  idle cycles (KB_OUT=00) between frames; >=1
// PORTS
//  CLK_IN       in   1  system clock, rising edge
//  RESET_IN     in   1  asynchronous, active-low reset
//  KEY_VALID    in   1  one-cycle pulse: KEY_CODE is a new key
//  KEY_CODE     in   2  key code from scanner
//  CLR_OVF      in   1  synchronous clear of OVERFLOW
//  KB_OUT       out  2  code to alarm controller (drives its KB_IN)
//  KB_SEND      out  1  strobe to alarm controller (drives its KB_RECV)
//  FIFO_FULL    out  1  FIFO holds DEPTH entries
//  BUSY         out  1  FSM not IDLE or FIFO non-empty
//  OVERFLOW     out  1  sticky: a key was dropped
// BEHAVIOUR
//  Reset (async, RESET_IN=0):
//   - KB_OUT=00, KB_SEND=0, FIFO_FULL=0, BUSY=0, OVERFLOW=0.
//   - FIFO emptied, FSM=IDLE. Applies immediately, also mid-frame; a partial strobe is truncated.
//  FIFO: a KEY_VALID pulse writes at the rising edge.
//   - Full with no pop that cycle: key dropped, OVERFLOW<=1.
//   - Full with a pop the same cycle: write accepted.
//   - Pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.
//  OVERFLOW: set has priority over CLR_OVF in the same cycle.
//  FSM states IDLE, SETUP, STROBE, HOLD, GAP; one down-counter reloaded on each state entry.
//   - IDLE:   FIFO non-empty -> pop head into KB_OUT, go SETUP.
//   - SETUP:  KB_SEND=0 for SETUP_CYC cycles -> STROBE.
//   - STROBE: KB_SEND=1 for STROBE_CYC cycles -> HOLD.
//   - HOLD:   KB_SEND=0, KB_OUT unchanged, HOLD_CYC cycles -> GAP.
//   - GAP:    KB_OUT=00, GAP_CYC cycles; then if FIFO non-empty pop and go SETUP, else IDLE.
//  Outputs: KB_OUT and KB_SEND are registered. KB_OUT never changes while KB_SEND=1.
//  Latency (key written at edge E into empty FIFO, FSM in IDLE):
//   - KB_OUT valid after E+1.
//   - KB_SEND=1 after E+1+SETUP_CYC, for STROBE_CYC cycles.
//  Back-to-back frame period is SETUP+STROBE+HOLD+GAP cycles (5 with defaults); the FSM does not return to IDLE between frames.
//  Order: codes are sent strictly in FIFO order. Code 00 is a legal key and is framed like any other.
//  FIFO_FULL and BUSY are combinational from registered state.
// TESTING
//  1. Reset low mid-STROBE -> KB_SEND=0, KB_OUT=00 immediately; after release BUSY=0, no residual frame.
//  2. Single key 2'b11 at edge E, defaults:
//     - KB_OUT=11 from E+1; KB_SEND high during cycles E+2..E+3; KB_OUT=11 through E+4; 00 at E+5; IDLE at E+6.
//  3. Keys 01,10,11 on consecutive cycles -> three frames in order 01,10,11, strobes 5 cycles apart; OVERFLOW=0.
//  4. Overflow: with KB_SEND timing stalled behind an active frame, write 6 keys while DEPTH=4.
//     - FIFO_FULL=1; extra keys dropped; OVERFLOW=1 until CLR_OVF; first 5 codes transmitted.
//  5. Write on the exact cycle of a pop while full -> accepted, FIFO_FULL stays 1, no OVERFLOW.
//  6. Params SETUP=2, STROBE=3, HOLD=2, GAP=1 -> KB_SEND high 3 cycles, rising 2 cycles after KB_OUT valid; period 8.

Source files
------------

// File: rtl/kb_link_tx.sv
// rtl/kb_link_tx.sv - keypad-side link transmitter: key FIFO plus timed setup/strobe/hold/gap framing.
// Each buffered code is replayed on KB_OUT with a registered KB_SEND strobe for the alarm controller.
module kb_link_tx #(
  parameter int DEPTH      = 4,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int GAP_CYC    = 1
) (
  input  logic       CLK_IN,
  input  logic       RESET_IN,
  input  logic       KEY_VALID,
  input  logic [1:0] KEY_CODE,
  input  logic       CLR_OVF,
  output logic [1:0] KB_OUT,
  output logic       KB_SEND,
  output logic       FIFO_FULL,
  output logic       BUSY,
  output logic       OVERFLOW
);

  localparam int AW = $clog2(DEPTH);
  localparam int M1 = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int M2 = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      kb_out_q, kb_out_d;
  logic            kb_send_q, kb_send_d;
  logic [1:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            fifo_empty, fifo_full;
  logic            pop, push;
  logic [1:0]      head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (AW + 1)'(DEPTH));
  assign head       = mem_q[rd_ptr_q];

  // A full FIFO still accepts a key when the FSM pops in the same cycle.
  assign push    = KEY_VALID && (!fifo_full || pop);
  assign count_d = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
  assign ovf_d   = (KEY_VALID && !push) ? 1'b1 : (CLR_OVF ? 1'b0 : ovf_q);

  always_ff @(posedge CLK_IN) begin
    if (push) begin
      mem_q[wr_ptr_q] <= KEY_CODE;
    end
  end

  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      kb_out_q  <= 2'b00;
      kb_send_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      kb_out_q  <= kb_out_d;
      kb_send_q <= kb_send_d;
    end
  end

  // The down-counter is loaded with (length-1) on state entry; the state exits when it reads zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    kb_out_d  = kb_out_q;
    kb_send_d = kb_send_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          kb_out_d = head;
          state_d  = S_SETUP;
          cnt_d    = CW'(SETUP_CYC - 1);
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d   = S_STROBE;
          kb_send_d = 1'b1;
          cnt_d     = CW'(STROBE_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          state_d   = S_HOLD;
          kb_send_d = 1'b0;
          cnt_d     = CW'(HOLD_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d  = S_GAP;
          kb_out_d = 2'b00;
          cnt_d    = CW'(GAP_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!fifo_empty) begin
          pop      = 1'b1;
          kb_out_d = head;
          state_d  = S_SETUP;
          cnt_d    = CW'(SETUP_CYC - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        kb_out_d  = 2'b00;
        kb_send_d = 1'b0;
      end
    endcase
  end

  assign KB_OUT    = kb_out_q;
  assign KB_SEND   = kb_send_q;
  assign FIFO_FULL = fifo_full;
  assign BUSY      = (state_q != S_IDLE) || !fifo_empty;
  assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_kb_link_tx.sv
// tb/tb_kb_link_tx.sv - randomized scoreboard bench for kb_link_tx, default and stretched frame timing.
// Each instance has a frame-timer reference model; a negedge monitor compares outputs and strobe order.
module tb_kb_link_tx;

  localparam int DEPTH = 4;

  typedef struct {
    logic [1:0] code;
    int         rise;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       kv = 1'b0;
  logic [1:0] kc = 2'b00;
  logic       clr = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  logic [1:0] kb_out [2];
  logic       kb_send [2];
  logic       full [2];
  logic       busy [2];
  logic       ovf [2];

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0d expected %0d at %0t", nm, g, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int SU = (g == 0) ? 1 : 2;
    localparam int ST = (g == 0) ? 2 : 3;
    localparam int HO = (g == 0) ? 1 : 2;
    localparam int GA = 1;
    localparam int P  = SU + ST + HO + GA;

    kb_link_tx #(
      .DEPTH(DEPTH), .SETUP_CYC(SU), .STROBE_CYC(ST), .HOLD_CYC(HO), .GAP_CYC(GA)
    ) dut (
      .CLK_IN(clk), .RESET_IN(rst_n), .KEY_VALID(kv), .KEY_CODE(kc), .CLR_OVF(clr),
      .KB_OUT(kb_out[g]), .KB_SEND(kb_send[g]), .FIFO_FULL(full[g]), .BUSY(busy[g]),
      .OVERFLOW(ovf[g])
    );

    logic [1:0] mq [$];
    exp_t       eq [$];
    int         rem = 0;
    int         ecnt = 0;
    bit         movf = 1'b0;
    logic [1:0] mcur = 2'b00;
    bit         m_busy = 1'b0;

    // Reference: a frame occupies P cycles from its pop; the next pop happens when the timer expires.
    always @(posedge clk or negedge rst_n) begin
      bit pop;
      if (!rst_n) begin
        mq.delete();
        eq.delete();
        rem  = 0;
        movf = 1'b0;
        mcur = 2'b00;
      end else begin
        ecnt++;
        if (rem > 0) rem--;
        pop = (rem == 0) && (mq.size() > 0);
        if (pop) begin
          mcur = mq.pop_front();
          rem  = P;
          eq.push_back('{mcur, ecnt + SU});
        end
        if (kv && mq.size() == DEPTH) begin
          movf = 1'b1;
        end else begin
          if (kv) mq.push_back(kc);
          if (clr) movf = 1'b0;
        end
      end
      m_busy = (rem > 0) || (mq.size() > 0);
    end

    bit         prev = 1'b0;
    int         st_start = 0;
    logic [1:0] scode = 2'b00;

    always @(negedge clk) begin
      int         k;
      logic [1:0] xo;
      logic       xs;
      exp_t       e;
      if (!rst_n) begin
        prev = 1'b0;
      end else begin
        k  = (rem > 0) ? (P - rem) : P;
        xo = (rem > 0 && k < SU + ST + HO) ? mcur : 2'b00;
        xs = (rem > 0 && k >= SU && k < SU + ST);
        chk("kb_out", g, kb_out[g], xo);
        chk("kb_send", g, kb_send[g], xs);
        chk("fifo_full", g, full[g], mq.size() == DEPTH);
        chk("busy", g, busy[g], (rem > 0) || (mq.size() > 0));
        chk("overflow", g, ovf[g], movf);
        if (kb_send[g] && !prev) begin
          if (eq.size() == 0) begin
            chk("unexpected_strobe", g, 1, 0);
          end else begin
            e = eq.pop_front();
            chk("strobe_code", g, kb_out[g], e.code);
            chk("strobe_rise", g, ecnt, e.rise);
          end
          st_start = ecnt;
          scode    = kb_out[g];
        end else if (kb_send[g]) begin
          chk("strobe_stable", g, kb_out[g], scode);
        end
        if (!kb_send[g] && prev) chk("strobe_width", g, ecnt - st_start, ST);
        prev = kb_send[g];
      end
    end
  end

  task automatic send_key(input logic [1:0] c);
    kv = 1'b1;
    kc = c;
    @(negedge clk);
    kv = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    while ((inst[0].m_busy || inst[1].m_busy) && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk("drain_timeout", 0, c < maxc, 1);
    repeat (2) @(negedge clk);
    chk("sb_left", 0, inst[0].eq.size(), 0);
    chk("sb_left", 1, inst[1].eq.size(), 0);
  endtask

  initial begin
    int w;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_kb_out", g, kb_out[g], 0);
      chk("rst_kb_send", g, kb_send[g], 0);
      chk("rst_full", g, full[g], 0);
      chk("rst_busy", g, busy[g], 0);
      chk("rst_ovf", g, ovf[g], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    send_key(2'b11);
    drain(60);

    send_key(2'b01);
    send_key(2'b10);
    send_key(2'b11);
    drain(100);

    for (int i = 0; i < 6; i++) send_key(2'((i + 1) % 4));
    for (int g = 0; g < 2; g++) begin
      chk("ovf_set", g, ovf[g], 1);
      chk("full_set", g, full[g], 1);
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) chk("ovf_sticky", g, ovf[g], 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int g = 0; g < 2; g++) chk("ovf_clr", g, ovf[g], 0);
    drain(200);

    // Continuous writes keep the FIFO full so some writes land on the pop cycle.
    for (int i = 0; i < 24; i++) send_key(2'($urandom_range(0, 3)));
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    drain(300);

    send_key(2'b10);
    w = 0;
    while (!kb_send[0] && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("strobe_wait", 0, w < 20, 1);
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("midrst_kb_send", g, kb_send[g], 0);
      chk("midrst_kb_out", g, kb_out[g], 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("postrst_busy", g, busy[g], 0);
      chk("postrst_kb_send", g, kb_send[g], 0);
    end

    for (int i = 0; i < 500; i++) begin
      kv  = ($urandom_range(0, 2) == 0);
      kc  = 2'($urandom_range(0, 3));
      clr = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    kv  = 1'b0;
    clr = 1'b0;
    drain(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
